dm1_4_buf: RTL and testbench

DM1_4_BUF -- requirements
Module: dm1_4_buf

---
 rtl/dm1_4_buf_pkg.sv | 8 +
 rtl/dm1_4_buf_slot.sv | 57 +++++
 rtl/dm1_4_buf.sv | 57 +++++
 tb/tb_dm1_4_buf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm1_4_buf_pkg.sv
// Shared constants and types for the 1-to-4 demultiplexing buffer.
package dm1_4_buf_pkg;
    localparam int DATA_W = 11;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/dm1_4_buf_slot.sv
// One output channel: single-entry holding register with valid flag and a
// modulo-256 delivered-word counter.
module dm_slot
    import dm1_4_buf_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] cnt
);
    logic             valid_q, valid_d;
    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_xfer;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        valid_d  = valid_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        out_xfer = valid_q & out_ready;

        if (out_xfer) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
        end
        // A load in the same cycle as a drain refills the slot with no bubble.
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    // NOTE: the data register is reset too, because out_data must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign cnt       = cnt_q;
endmodule

// File: rtl/dm1_4_buf.sv
// 1-to-4 demultiplexing buffer: routes each accepted word to the channel
// selected by in_sel; each channel drains independently.
module dm1_4_buf
    import dm1_4_buf_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  ch_idx_t           in_sel,
    input  logic [W-1:0]      in_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [W-1:0]      out_data0,
    output logic [W-1:0]      out_data1,
    output logic [W-1:0]      out_data2,
    output logic [W-1:0]      out_data3,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3
);
    logic [NUM_CH-1:0] load;
    logic [W-1:0]      data_arr [NUM_CH];
    logic [CNT_W-1:0]  cnt_arr  [NUM_CH];

    // Ready depends only on the addressed slot, never on in_valid.
    always_comb begin
        in_ready     = ~out_valid[in_sel] | out_ready[in_sel];
        load         = '0;
        load[in_sel] = in_valid & in_ready;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        dm_slot #(.W(W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (data_arr[k]),
            .cnt       (cnt_arr[k])
        );
    end

    assign out_data0 = data_arr[0];
    assign out_data1 = data_arr[1];
    assign out_data2 = data_arr[2];
    assign out_data3 = data_arr[3];
    assign cnt0      = cnt_arr[0];
    assign cnt1      = cnt_arr[1];
    assign cnt2      = cnt_arr[2];
    assign cnt3      = cnt_arr[3];
endmodule

// File: tb/tb_dm1_4_buf.sv
// Testbench for dm1_4_buf: directed scenarios with literal expectations plus a
// randomized run checked every cycle against four per-channel FIFO models.
module tb_dm1_4_buf;
    import dm1_4_buf_pkg::*;

    localparam int W = DATA_W;
    typedef logic [W-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    ch_idx_t           in_sel = '0;
    word_t             in_data = '0;
    logic [NUM_CH-1:0] out_valid;
    logic [NUM_CH-1:0] out_ready = '0;
    word_t             out_data0, out_data1, out_data2, out_data3;
    logic [7:0]        cnt0, cnt1, cnt2, cnt3;

    dm1_4_buf #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    always #5 clk = ~clk;

    word_t      dut_d [NUM_CH];
    logic [7:0] dut_c [NUM_CH];
    assign dut_d[0] = out_data0;
    assign dut_d[1] = out_data1;
    assign dut_d[2] = out_data2;
    assign dut_d[3] = out_data3;
    assign dut_c[0] = cnt0;
    assign dut_c[1] = cnt1;
    assign dut_c[2] = cnt2;
    assign dut_c[3] = cnt3;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO of pending words per channel, the last word
    // written to each channel, and a delivered-word count per channel.
    word_t mq [NUM_CH][$];
    word_t last_w [NUM_CH];
    int    mcnt [NUM_CH];
    logic [NUM_CH-1:0] prev_hold = '0;
    word_t prev_d [NUM_CH];

    function automatic void model_clear();
        for (int k = 0; k < NUM_CH; k++) begin
            mq[k].delete();
            last_w[k] = '0;
            mcnt[k]   = 0;
        end
        prev_hold = '0;
    endfunction

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        bit acc;
        if (rst_n) begin
            acc = in_valid && (mq[in_sel].size() == 0 || out_ready[in_sel]);
            for (int k = 0; k < NUM_CH; k++) begin
                if (out_ready[k] && mq[k].size() != 0) begin
                    void'(mq[k].pop_front());
                    mcnt[k] = (mcnt[k] + 1) % 256;
                end
            end
            if (acc) begin
                mq[in_sel].push_back(in_data);
                last_w[in_sel] = in_data;
            end
        end
    end

    always @(negedge clk) begin
        bit exp_v;
        if (rst_n && chk_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                exp_v = (mq[k].size() != 0);
                check($sformatf("valid%0d", k), {31'd0, out_valid[k]}, {31'd0, exp_v});
                check($sformatf("data%0d", k), 32'(dut_d[k]), 32'(exp_v ? mq[k][0] : last_w[k]));
                check($sformatf("cnt%0d", k), 32'(dut_c[k]), 32'(mcnt[k]));
                if (prev_hold[k])
                    check($sformatf("stable%0d", k), 32'(dut_d[k]), 32'(prev_d[k]));
                prev_hold[k] = out_valid[k] && !out_ready[k];
                prev_d[k]    = dut_d[k];
            end
            check("in_ready", {31'd0, in_ready},
                  {31'd0, (mq[in_sel].size() == 0 || out_ready[in_sel])});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        model_clear();
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic send(input int ch, input word_t d);
        in_valid = 1'b1;
        in_sel   = ch_idx_t'(ch);
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit stream_ok;
        model_clear();
        chk_en = 1'b1;

        // Reset state and ready for every in_sel.
        do_reset();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_cnt", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
        for (int s = 0; s < NUM_CH; s++) begin
            in_sel = ch_idx_t'(s);
            #1;
            check($sformatf("rst_ready_sel%0d", s), {31'd0, in_ready}, 32'd1);
        end

        // Single word through channel 2.
        do_reset();
        out_ready = 4'b0100;
        send(2, 11'h5A5);
        check("basic_valid", 32'(out_valid), 32'h4);
        check("basic_data2", 32'(out_data2), 32'h5A5);
        tick();
        check("basic_drain_valid", 32'(out_valid), 32'h0);
        check("basic_cnt2", 32'(cnt2), 32'd1);

        // Backpressure on channel 1.
        do_reset();
        send(1, 11'h001);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 11'h002;
        #1;
        check("bp_ready_low", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data1", 32'(out_data1), 32'h001);
        end
        out_ready = 4'b0010;
        #1;
        check("bp_ready_high", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_swap_data1", 32'(out_data1), 32'h002);
        check("bp_swap_valid", 32'(out_valid), 32'h2);
        check("bp_swap_cnt1", 32'(cnt1), 32'd1);
        tick();
        check("bp_final_cnt1", 32'(cnt1), 32'd2);
        check("bp_final_valid", 32'(out_valid), 32'h0);

        // Streaming 300 words to channel 3.
        do_reset();
        out_ready = 4'b1111;
        stream_ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'd3;
            in_data  = word_t'(i);
            #1;
            if (in_ready !== 1'b1) stream_ok = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("stream_ready_always", {31'd0, stream_ok}, 32'd1);
        check("stream_cnt3", 32'(cnt3), 32'd44);
        check("stream_empty", 32'(out_valid), 32'h0);

        // Fan-out: fill all four, drain together.
        do_reset();
        send(0, 11'h100);
        send(1, 11'h200);
        send(2, 11'h300);
        send(3, 11'h7FF);
        check("fan_valid", 32'(out_valid), 32'hF);
        check("fan_data0", 32'(out_data0), 32'h100);
        check("fan_data1", 32'(out_data1), 32'h200);
        check("fan_data2", 32'(out_data2), 32'h300);
        check("fan_data3", 32'(out_data3), 32'h7FF);
        out_ready = 4'b1111;
        tick();
        check("fan_drained", 32'(out_valid), 32'h0);
        check("fan_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h01010101);

        // Asynchronous reset with channels 0 and 3 full and non-zero counts.
        do_reset();
        out_ready = 4'b1001;
        send(0, 11'h0AA);
        send(3, 11'h155);
        send(3, 11'h2AB);
        out_ready = 4'b0000;
        send(0, 11'h0CC);
        check("ar_pre_valid", 32'(out_valid), 32'h9);
        check("ar_pre_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h01000001);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'h0);
        check("ar_cnts", {cnt0, cnt1, cnt2, cnt3}, 32'h0);
        check("ar_data0", 32'(out_data0), 32'h0);
        check("ar_data3", 32'(out_data3), 32'h0);
        #3;
        rst_n = 1'b1;
        send(0, 11'h3C3);
        check("ar_first_xfer", 32'(out_valid), 32'h1);
        check("ar_first_data", 32'(out_data0), 32'h3C3);

        // Randomized run against the FIFO models.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = ch_idx_t'($urandom_range(0, 3));
            in_data   = word_t'($urandom);
            out_ready = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
